latch_load_sequencer: RTL and testbench
=======================================

# latch_load_sequencer

Upstream driver for a bank of WIDTH gated D latches (D/En style, transparent while En high). It collects a serial bit stream over a valid/ready handshake and presents the assembled word on a parallel D bus. It then issues a single enable pulse framed by guaranteed data-stable setup and hold windows, so the latch never samples a changing D. Fully synchronous; latches sit directly downstream on d_out/en_out.

## Interface
- WIDTH, 4: word width in bits; ≥2.
- SETUP_CYC, 1: cycles d_out is stable before en_out rises; ≥1.
- EN_CYC, 1: cycles en_out stays high; ≥1.
- HOLD_CYC, 1: cycles d_out stays stable after en_out falls; ≥1.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  1  serial data bit, MSB first.
- s_valid  in  1  s_data valid this cycle.
- s_ready  out  1  sequencer accepts a bit this cycle.
- d_out  out  WIDTH  word presented to the latch D inputs.
- en_out  out  1  latch enable; registered, glitch-free.
- busy  out  1  high whenever state ≠ COLLECT.
- done  out  1  one-cycle pulse when a word's HOLD window completes.

## Operation
- States: COLLECT, SETUP, ENABLE, HOLD.
- Reset values (after an edge with rst=1):
  - state=COLLECT, bit count=0, shift reg=0, timer=0.
  - d_out=0, en_out=0, done=0, busy=0, s_ready=1.
- COLLECT:
  - s_ready=1.
  - Accept on s_valid&&s_ready: shreg <= {shreg[WIDTH-2:0], s_data}, count++.
  - If s_valid is low, hold count and shreg unchanged.
- Last bit accepted (count==WIDTH-1 with accept):
  - On the same edge: d_out <= {shreg[WIDTH-2:0], s_data}, count <= 0, state <= SETUP, timer cleared.
- SETUP:
  - s_ready=0, en_out=0.
  - After SETUP_CYC cycles → ENABLE; en_out registered high on that edge.
- ENABLE:
  - en_out=1 for exactly EN_CYC cycles → HOLD; en_out registered low on that edge.
- HOLD:
  - en_out=0 for HOLD_CYC cycles → COLLECT.
  - On that edge: done=1 for one cycle, s_ready returns to 1.
- d_out changes only on a last-bit accept edge or on reset; it holds the previous word through COLLECT.
- Input while s_ready=0: s_valid is ignored and no bit is consumed. The upstream source must keep the bit pending.
- s_data is don't-care when s_valid=0.
- Reset mid-operation: partial word discarded, count cleared, en_out forced low. d_out clears to 0 on the same edge. This is the only permitted D change concurrent with an en_out fall.

## Timing
- Edge E0 accepts the last bit.
- d_out = new word from E0.
- en_out high from E0+SETUP_CYC to E0+SETUP_CYC+EN_CYC.
- done high for the single cycle after E0+SETUP_CYC+EN_CYC+HOLD_CYC; s_ready high from that same edge.
- A new first bit may be accepted in the done cycle.
- Minimum word period: WIDTH+SETUP_CYC+EN_CYC+HOLD_CYC cycles. Defaults: 7.
- Invariant: d_out never changes while en_out=1, nor within SETUP_CYC cycles before or HOLD_CYC cycles after an en_out pulse (except on reset).
- No combinational path from s_valid to s_ready. s_ready is decoded from state only.

## Structure
- Shared package latch_seq_pkg:
  - State encoding localparams: COLLECT=2'd0, SETUP=2'd1, ENABLE=2'd2, HOLD=2'd3.
  - Count width $clog2(WIDTH+1).
  - Timer width $clog2(max(SETUP_CYC,EN_CYC,HOLD_CYC)+1).
- One sub-module, phase_timer:
  - Loadable down-counter with load/terminal-count outputs.
  - Reused for all three windows; reloaded on each state entry.
- Top-level latch_load_sequencer holds the FSM, shift register, bit counter and output registers.

## Test plan
- Basic word (defaults): send 1,0,1,1 with s_valid continuous → d_out=4'b1011 on E0; en_out high for exactly 1 cycle starting at E0+1; done pulse at E0+3; busy high E0..E0+2.
- Backpressure: drive s_valid=1 with bit 0 during SETUP/ENABLE/HOLD → no bit consumed, count stays 0. After done, the next word 0110 yields d_out=4'b0110.
- Gapped input: bits 1,1,0,0 with s_valid low for 3 cycles between each → d_out=4'b1100 only after the 4th accept; d_out holds the previous word until then.
- Stretched windows (SETUP_CYC=3, EN_CYC=2, HOLD_CYC=2): d_out unchanged for 3 cycles before, 2 during and 2 after en_out; done at E0+7.
- Reset mid-ENABLE: assert rst while en_out=1 → next edge en_out=0, d_out=0, s_ready=1, busy=0. A following full word loads cleanly with no stale bits.
- Back-to-back: two words streamed with s_valid held high → second word's first bit accepted in the done cycle; 7-cycle word period; no en_out overlap.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared state encoding and width helpers for the latch load sequencer.
package latch_seq_pkg;

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] ENABLE  = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Wide enough to hold the longest window length.
    function automatic int timer_width(input int setup_cyc, input int en_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (en_cyc > m)   m = en_cyc;
        if (hold_cyc > m) m = hold_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/latch_load_sequencer_phase_timer.sv
// Loadable down-counter timing the SETUP, ENABLE and HOLD windows.
module phase_timer #(
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          tc_o
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count: the current window ends at the next edge.
    assign tc_o = (count_q == '0);

endmodule

// File: rtl/latch_load_sequencer.sv
// Collects a serial word and drives it to a latch bank with a framed enable pulse.
module latch_load_sequencer
    import latch_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = count_width(WIDTH);
    localparam int TW = timer_width(SETUP_CYC, EN_CYC, HOLD_CYC);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] EN_LD    = TW'(EN_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic             en_q, en_d;
    logic             done_q, done_d;

    logic             timer_load;
    logic [TW-1:0]    timer_val;
    logic             timer_tc;
    logic [WIDTH-1:0] shifted;

    assign shifted = {shreg_q, s_data};

    phase_timer #(
        .TW(TW)
    ) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .tc_o      (timer_tc)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shreg_d    = shreg_q;
        d_out_d    = d_out_q;
        en_d       = en_q;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_q)
            COLLECT: begin
                if (s_valid) begin
                    if (count_q == LAST_BIT) begin
                        d_out_d    = shifted;
                        count_d    = '0;
                        shreg_d    = '0;
                        state_d    = SETUP;
                        timer_load = 1'b1;
                        timer_val  = SETUP_LD;
                    end else begin
                        shreg_d = shifted[WIDTH-2:0];
                        count_d = count_q + 1'b1;
                    end
                end
            end
            SETUP: begin
                if (timer_tc) begin
                    state_d    = ENABLE;
                    en_d       = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = EN_LD;
                end
            end
            ENABLE: begin
                if (timer_tc) begin
                    state_d    = HOLD;
                    en_d       = 1'b0;
                    timer_load = 1'b1;
                    timer_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (timer_tc) begin
                    state_d = COLLECT;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            count_q <= '0;
            shreg_q <= '0;
            d_out_q <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            d_out_q <= d_out_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // Ready is decoded from state alone so s_valid never reaches it combinationally.
    assign s_ready = (state_q == COLLECT);
    assign busy    = (state_q != COLLECT);
    assign d_out   = d_out_q;
    assign en_out  = en_q;
    assign done    = done_q;

endmodule

// File: tb/tb_latch_load_sequencer.sv
// Scoreboard bench: default-parameter sequencer plus a stretched-window instance.
module tb_latch_load_sequencer;

    logic       clk;
    logic       rst;
    logic       a_data, a_valid, a_ready, a_en, a_busy, a_done;
    logic [3:0] a_d;
    logic       b_data, b_valid, b_ready, b_en, b_busy, b_done;
    logic [3:0] b_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [3:0] word;
        int         e0;
    } exp_t;

    exp_t exp_q[$];
    exp_t act;
    bit   act_valid = 0;
    int   rise_cyc  = 0;
    logic prev_en   = 0;
    logic prev_done = 0;
    logic [3:0] prev_d = '0;

    latch_load_sequencer #(
        .WIDTH(4), .SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1)
    ) u_dut (
        .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
        .d_out(a_d), .en_out(a_en), .busy(a_busy), .done(a_done)
    );

    latch_load_sequencer #(
        .WIDTH(4), .SETUP_CYC(3), .EN_CYC(2), .HOLD_CYC(2)
    ) u_dut_str (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
        .d_out(b_d), .en_out(b_en), .busy(b_busy), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor for the default instance: pops expected words on each enable pulse.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            act_valid = 0;
        end else begin
            if (a_d != prev_d)
                chk("d_change_quiet", {30'd0, prev_en, a_en}, 32'd0);
            if (a_en && !prev_en) begin
                chk("sb_nonempty_at_en", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    act       = exp_q.pop_front();
                    act_valid = 1;
                    rise_cyc  = cyc;
                    $display("[TB] cycle %0d en rise d_out=%b expected %b", cyc, a_d, act.word);
                    chk("d_at_en_rise", a_d, act.word);
                    chk("setup_len", cyc - act.e0, 1);
                    chk("busy_in_enable", a_busy, 1);
                end
            end
            if (!a_en && prev_en)
                chk("en_width", cyc - rise_cyc, 1);
            if (a_done) begin
                chk("done_repeat", prev_done, 0);
                chk("done_expected", act_valid, 1);
                if (act_valid) begin
                    chk("done_latency", cyc - act.e0, 3);
                    chk("d_hold_done", a_d, act.word);
                    chk("busy_at_done", a_busy, 0);
                    chk("ready_at_done", a_ready, 1);
                    act_valid = 0;
                end
            end
        end
        prev_en   = a_en;
        prev_d    = a_d;
        prev_done = a_done;
    end

    task automatic send_bit(input logic b, output int acc);
        bit ok;
        ok      = 0;
        acc     = -1;
        a_valid = 1'b1;
        a_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            logic r;
            r = a_ready;
            @(negedge clk);
            if (r) begin
                ok  = 1;
                acc = cyc;
            end
        end
        if (!ok) chk("accept_timeout", ok, 1);
    endtask

    task automatic send_word(input logic [3:0] w, input int gap, input logic [3:0] prev_word,
                             output int e0, output int first_acc);
        logic [3:0] m;
        int acc;
        m = '0;
        first_acc = -1;
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i], acc);
            m = {m[2:0], w[i]};
            if (i == 3) first_acc = acc;
            if (i > 0 && gap > 0) begin
                a_valid = 1'b0;
                repeat (gap) @(negedge clk);
                chk("d_hold_gap", a_d, prev_word);
            end
        end
        e0 = acc;
        exp_q.push_back('{word: m, e0: acc});
        $display("[TB] cycle %0d word %b accepted", e0, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        int e0a, e0b, fa, fb;
        logic [3:0] bw;
        rst     = 1'b1;
        a_valid = 1'b0; a_data = 1'b0;
        b_valid = 1'b0; b_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_d", a_d, 4'd0);
        chk("rst_en", a_en, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_ready_str", b_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Basic word followed immediately by a backpressured pending bit.
        send_word(4'b1011, 0, 4'd0, e0a, fa);
        a_data = 1'b0;
        chk("basic_d", a_d, 4'b1011);
        chk("basic_busy", a_busy, 1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready_low", a_ready, 0);
            chk("bp_d_hold", a_d, 4'b1011);
            @(negedge clk);
        end
        send_word(4'b0110, 0, 4'd0, e0a, fa);
        a_valid = 1'b0;
        chk("bp_word", a_d, 4'b0110);
        repeat (6) @(negedge clk);

        send_word(4'b1100, 3, 4'b0110, e0a, fa);
        a_valid = 1'b0;
        chk("gap_word", a_d, 4'b1100);
        repeat (6) @(negedge clk);

        // Reset while the enable pulse is high.
        send_word(4'b1001, 0, 4'd0, e0a, fa);
        a_valid = 1'b0;
        for (int t = 0; t < 10 && !a_en; t++) @(negedge clk);
        chk("rst_mid_en_seen", a_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_en", a_en, 0);
        chk("rst_mid_d", a_d, 4'd0);
        chk("rst_mid_ready", a_ready, 1);
        chk("rst_mid_busy", a_busy, 0);
        rst = 1'b0;
        @(negedge clk);
        send_word(4'b0101, 0, 4'd0, e0a, fa);
        a_valid = 1'b0;
        chk("post_rst_word", a_d, 4'b0101);
        repeat (6) @(negedge clk);

        // Back-to-back words with s_valid held high.
        send_word(4'b1110, 0, 4'd0, e0a, fa);
        send_word(4'b0011, 0, 4'd0, e0b, fb);
        a_valid = 1'b0;
        chk("b2b_first_in_done", fb - e0a, 4);
        chk("b2b_period", e0b - e0a, 7);
        chk("b2b_word", a_d, 4'b0011);
        repeat (6) @(negedge clk);

        // Stretched windows on the second instance.
        bw = 4'b1010;
        b_valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            chk("str_ready", b_ready, 1);
            b_data = bw[i];
            @(negedge clk);
        end
        b_valid = 1'b0;
        e0a = cyc;
        for (int k = 0; k < 10; k++) begin
            int kk;
            kk = cyc - e0a;
            $display("[TB] str k=%0d en=%b done=%b d_out=%b", kk, b_en, b_done, b_d);
            chk("str_en", b_en, (kk >= 3 && kk < 5));
            chk("str_done", b_done, (kk == 7));
            chk("str_d", b_d, bw);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
